// File: rtl/spawn_scheduler.sv
// Frame-driven spawn scheduler: warm-up FSM, per-lane object lifetimes, global launch gap,
// and a round-robin single-grant arbiter that launches at most one lane per video frame.
module spawn_lane #(
    parameter int TRAVEL_FRAMES = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic launch,
    output logic active
);
    localparam int LW = ($clog2(TRAVEL_FRAMES + 1) < 1) ? 1 : $clog2(TRAVEL_FRAMES + 1);

    logic [LW-1:0] life;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      life <= '0;
        else if (launch)                 life <= LW'(TRAVEL_FRAMES);
        else if (tick && life != '0)     life <= life - 1'b1;
    end

    assign active = (life != '0);
endmodule

module spawn_scheduler #(
    parameter int LANES         = 3,
    parameter int MAX_ACTIVE    = 2,
    parameter int TRAVEL_FRAMES = 12,
    parameter int MIN_GAP       = 4,
    parameter int WARMUP        = 30
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       run,
    input  logic                       frame_tick,
    input  logic [19:0]                random,
    output logic [LANES-1:0]           spawn_en,
    output logic [LANES-1:0]           active,
    output logic [$clog2(LANES+1)-1:0] active_count,
    output logic [1:0]                 state,
    output logic [15:0]                spawned_total
);
    localparam int CW = $clog2(LANES + 1);
    localparam int PW = ($clog2(LANES) < 1) ? 1 : $clog2(LANES);
    localparam int GW = ($clog2(MIN_GAP + 1) < 1) ? 1 : $clog2(MIN_GAP + 1);
    localparam int WW = ($clog2(WARMUP + 1) < 1) ? 1 : $clog2(WARMUP + 1);

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_WARM = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;

    logic [PW-1:0]    rr_ptr, rr_next;
    logic [GW-1:0]    gap;
    logic [WW-1:0]    warm;
    logic [LANES-1:0] req, elig, grant;
    logic             grant_ok;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            assign req[g] = &random[3*g +: 3];
            spawn_lane #(.TRAVEL_FRAMES(TRAVEL_FRAMES)) u_lane (
                .clk    (clk),
                .rst_n  (rst_n),
                .tick   (frame_tick),
                .launch (grant[g]),
                .active (active[g])
            );
        end
    endgenerate

    always_comb begin
        active_count = '0;
        for (int i = 0; i < LANES; i++) active_count = active_count + CW'(active[i]);
    end

    // Eligibility and capacity look at pre-tick lifetimes, so a lane expiring this tick waits a frame.
    assign elig     = req & ~active & {LANES{frame_tick && run && state == S_RUN}};
    assign grant_ok = (|elig) && (gap == '0) && (32'(active_count) < MAX_ACTIVE);

    always_comb begin
        grant   = '0;
        rr_next = rr_ptr;
        for (int off = 0; off < LANES; off++) begin
            int idx;
            idx = int'(rr_ptr) + off;
            if (idx >= LANES) idx = idx - LANES;
            if (grant_ok && grant == '0 && elig[idx]) begin
                grant[idx] = 1'b1;
                rr_next    = (idx + 1 == LANES) ? '0 : PW'(idx + 1);
            end
        end
    end

    // Dropping run leaves IDLE immediately, independent of the frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            warm  <= '0;
        end else if (!run) begin
            state <= S_IDLE;
            warm  <= '0;
        end else if (frame_tick) begin
            case (state)
                S_IDLE: begin
                    state <= S_WARM;
                    warm  <= WW'(WARMUP);
                end
                S_WARM: begin
                    if (warm == '0) state <= S_RUN;
                    else            warm  <= warm - 1'b1;
                end
                S_RUN:   state <= S_RUN;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spawn_en      <= '0;
            gap           <= '0;
            rr_ptr        <= '0;
            spawned_total <= '0;
        end else begin
            spawn_en <= grant;
            if (|grant) begin
                gap           <= GW'(MIN_GAP);
                rr_ptr        <= rr_next;
                spawned_total <= spawned_total + 16'd1;
            end else if (frame_tick && gap != '0) begin
                gap <= gap - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spawn_scheduler.sv
// Bench for spawn_scheduler: directed warm-up/reset scenarios plus randomized frames,
// every cycle compared against a frame-level reference model held in plain integers.
module tb_spawn_scheduler;
    localparam int LANES = 3, MAX_ACTIVE = 2, TRAVEL = 12, MIN_GAP = 4, WARMUP = 30;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             run = 1'b0;
    logic             frame_tick = 1'b0;
    logic [19:0]      random = '0;
    logic [LANES-1:0] spawn_en, active;
    logic [1:0]       active_count, state;
    logic [15:0]      spawned_total;

    int compared = 0, mismatched = 0;

    // reference model: mode 0 idle, 1 warming up, 2 running
    int m_mode, m_warm, m_gap, m_rr, m_total, m_spawn;
    int m_life[LANES];

    always #5 clk = ~clk;

    spawn_scheduler #(.LANES(LANES), .MAX_ACTIVE(MAX_ACTIVE), .TRAVEL_FRAMES(TRAVEL),
                      .MIN_GAP(MIN_GAP), .WARMUP(WARMUP)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .frame_tick(frame_tick), .random(random),
        .spawn_en(spawn_en), .active(active), .active_count(active_count),
        .state(state), .spawned_total(spawned_total)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_warm = 0; m_gap = 0; m_rr = 0; m_total = 0; m_spawn = 0;
        for (int i = 0; i < LANES; i++) m_life[i] = 0;
    endtask

    task automatic model_step(input logic t, input logic r, input logic [19:0] rnd);
        int busy, k;
        m_spawn = 0;
        if (t) begin
            busy = 0;
            k = -1;
            for (int i = 0; i < LANES; i++) if (m_life[i] > 0) busy++;
            if (r && m_mode == 2 && m_gap == 0 && busy < MAX_ACTIVE)
                for (int off = 0; off < LANES && k < 0; off++) begin
                    int ln = (m_rr + off) % LANES;
                    if (rnd[3*ln +: 3] == 3'b111 && m_life[ln] == 0) k = ln;
                end
            for (int i = 0; i < LANES; i++)
                if (i == k) m_life[i] = TRAVEL;
                else if (m_life[i] > 0) m_life[i]--;
            if (k >= 0) begin
                m_gap   = MIN_GAP;
                m_spawn = 1 << k;
                m_rr    = (k + 1) % LANES;
                m_total = (m_total + 1) % 65536;
            end else if (m_gap > 0) m_gap--;
        end
        if (!r) begin
            m_mode = 0; m_warm = 0;
        end else if (t) begin
            if (m_mode == 0) begin m_mode = 1; m_warm = WARMUP; end
            else if (m_mode == 1) begin
                if (m_warm == 0) m_mode = 2;
                else m_warm--;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [LANES-1:0] act;
        int cnt;
        act = '0;
        cnt = 0;
        for (int i = 0; i < LANES; i++) if (m_life[i] > 0) begin act[i] = 1'b1; cnt++; end
        check({tag, ".spawn_en"}, 32'(spawn_en), 32'(m_spawn));
        check({tag, ".active"}, 32'(active), 32'(act));
        check({tag, ".active_count"}, 32'(active_count), 32'(cnt));
        check({tag, ".state"}, 32'(state), 32'(m_mode));
        check({tag, ".total"}, 32'(spawned_total), 32'(m_total));
    endtask

    // one clk cycle: drive at the falling edge, check 1 time unit after the rising edge
    task automatic step(input string tag, input logic t, input logic r, input logic [19:0] rnd);
        frame_tick = t; run = r; random = rnd;
        model_step(t, r, rnd);
        @(posedge clk);
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    initial begin
        int first_tick, second_tick, warm_ticks, budget;
        logic [LANES-1:0] first_val, second_val;
        logic [19:0] rnd;

        model_reset();
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_no_run", 1'b1, 1'b0, '1);

        // warm-up timing: tick 0 enters warm-up
        first_tick = -1; second_tick = -1; warm_ticks = 0;
        first_val = '0; second_val = '0;
        for (int tk = 0; tk < 45; tk++) begin
            step("warm", 1'b1, 1'b1, '1);
            if (state == 2'b01) warm_ticks++;
            if (spawn_en != '0) begin
                if (first_tick < 0) begin first_tick = tk; first_val = spawn_en; end
                else if (second_tick < 0) begin second_tick = tk; second_val = spawn_en; end
            end
            for (int c = 0; c < 15; c++) step("warm_gap", 1'b0, 1'b1, '1);
        end
        check("warm_ticks", warm_ticks, 31);
        check("first_tick", first_tick, 32);
        check("first_lane", 32'(first_val), 32'h1);
        check("second_delta", second_tick - first_tick, 5);
        check("second_lane", 32'(second_val), 32'h2);

        // drain everything, then request lane 2 alone
        for (int tk = 0; tk < 20; tk++) step("drain", 1'b1, 1'b1, 20'h0);
        step("lane2", 1'b1, 1'b1, 20'h001C0);
        check("lane2_spawn", 32'(spawn_en), 32'h4);
        check("lane2_count", 32'(active_count), 32'd1);
        for (int tk = 0; tk < 11; tk++) step("lane2_life", 1'b1, 1'b1, 20'h0);
        check("lane2_still", 32'(active[2]), 32'd1);
        step("lane2_expire", 1'b1, 1'b1, 20'h0);
        check("lane2_gone", 32'(active[2]), 32'd0);

        // randomized frames, run drops, request churn between ticks
        for (int n = 0; n < 3000; n++) begin
            rnd = 20'($urandom);
            for (int i = 0; i < LANES; i++) if ($urandom_range(0, 1) == 1) rnd[3*i +: 3] = 3'b111;
            step("rand", ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) != 0), rnd);
        end

        // reset landing while a launch pulse is pending
        budget = 0;
        while (spawn_en == '0 && budget < 400) begin
            step("pre_rst", 1'b1, 1'b1, '1);
            budget++;
        end
        check("pre_rst_seen", 32'(budget < 400), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1'b1, 1'b0, '1);
        step("post_rst2", 1'b1, 1'b1, '1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/spawn_scheduler.md
SPAWN_SCHEDULER -- requirements
Module: spawn_scheduler

Interface
REQ-001 Parameter LANES, default 3, number of object lanes (one spawn engine per lane).
REQ-002 Parameter MAX_ACTIVE, default 2, maximum lanes with an object in flight at once.
REQ-003 Parameter TRAVEL_FRAMES, default 12, frames an object occupies its lane after launch.
REQ-004 Parameter MIN_GAP, default 4, minimum frames between two consecutive launches.
REQ-005 Parameter WARMUP, default 30, frames of no spawning after run asserts.
REQ-006 clk  input  1  system clock (CLK100MHZ domain); the block has one clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 run  input  1  level; 1 = gameplay active, 0 = halt spawning.
REQ-009 frame_tick  input  1  single-cycle pulse per video frame, synchronous to clk.
REQ-010 random  input  20  LFSR word; lane i requests when random[3i+2:3i] == 3'b111.
REQ-011 spawn_en  output  LANES  one-cycle launch pulse per lane, to that lane's spawn engine.
REQ-012 active  output  LANES  1 = lane has an object in flight.
REQ-013 active_count  output  $clog2(LANES+1)  population count of active.
REQ-014 state  output  2  00 IDLE, 01 WARMUP, 10 RUN.
REQ-015 spawned_total  output  16  launches since reset, wraps 0xFFFF -> 0x0000.

Function
REQ-016 All state updates except spawn_en clearing and IDLE entry occur only on cycles with frame_tick = 1 ("tick").
REQ-017 FSM: IDLE -> WARMUP on tick with run = 1, warm counter loaded with WARMUP.
REQ-018 WARMUP: warm counter decrements per tick; tick with counter = 0 -> RUN (no grant on that tick).
REQ-019 Any state -> IDLE on the first clk cycle run = 0, tick or not; warm counter cleared.
REQ-020 Per-lane lifetime counter: on launch loaded with TRAVEL_FRAMES; each tick, nonzero decrements; active[i] = (lifetime[i] != 0).
REQ-021 Lifetimes keep draining in IDLE and WARMUP; in-flight objects are never cancelled by run = 0.
REQ-022 Gap counter: loaded with MIN_GAP on launch; decrements per tick while nonzero, in every state.
REQ-023 Lane eligible on a tick iff requested (REQ-010), active[i] = 0 using pre-tick value, state = RUN.
REQ-024 Grant on a tick iff some lane eligible, gap counter = 0 (pre-tick), active_count < MAX_ACTIVE (pre-tick).
REQ-025 At most one grant per tick; round-robin: search starts at rr_ptr, ascending modulo LANES; first eligible wins.
REQ-026 On grant of lane k: rr_ptr <= (k+1) mod LANES; lifetime[k], gap counter, spawned_total updated on the tick cycle.
REQ-027 Latency: spawn_en[k] is 1 on the clk cycle after the granting tick, 0 otherwise; never two bits high at once.
REQ-028 A lane expiring on tick T is not eligible until tick T+1 (eligibility uses pre-tick active).
REQ-029 Counters saturate at 0 and never underflow; lifetime and gap widths sized from TRAVEL_FRAMES / MIN_GAP.
REQ-030 random sampled only on the tick cycle; changes between ticks have no effect.

Reset
REQ-031 rst_n = 0 asynchronously forces: state IDLE, spawn_en 0, active 0, active_count 0, spawned_total 0, all lifetimes, gap and warm counters 0, rr_ptr 0.
REQ-032 Reset mid-flight discards all in-flight objects and any pending spawn_en pulse immediately.
REQ-033 After rst_n rises the block waits in IDLE for run = 1 and a tick.

Verification
REQ-034 run = 1, random = all-ones, ticks every 16 clk -> state WARMUP for 31 ticks, first spawn_en = 3'b001 one clk after tick 32, then 3'b010 exactly 5 ticks later.
REQ-035 RUN, random = all-ones continuously, MAX_ACTIVE = 2 -> never more than 2 active; third lane launches only after lane 0 expires 12 ticks post-launch.
REQ-036 RUN, lanes idle, gap = 0, random = 20'h001C0 (lane 2 only) -> spawn_en = 3'b100 single clk; lifetime[2] = 12; active_count = 1.
REQ-037 Lane 0 expiring on the same tick lane 0 is requested -> no grant to lane 0 that tick; grant on next tick if still requested.
REQ-038 run dropped with 2 lanes active -> state IDLE next clk, no further spawn_en, active drains to 0 over remaining ticks.
REQ-039 rst_n pulsed low between a grant tick and its spawn_en cycle -> spawn_en stays 0, all outputs at reset values, spawned_total = 0.
